// File: rtl/proc_pkg.sv
// proc_pkg: shared decoder constants and the input-port handshake state encoding
package proc_pkg;
   localparam logic [1:0] TYPE_ALU = 2'b00;
   localparam logic [3:0] OP_IN    = 4'b1001;
   typedef enum logic [1:0] {PIN_IDLE, PIN_STALL, PIN_ACK} pin_state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep single-bit synchroniser for asynchronous inputs
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sr;
   always_ff @(posedge clk)
      sr <= !reset_n ? '0 : {sr[STAGES-2:0], d};
   assign q = sr[STAGES-1];
endmodule

// File: rtl/periph_in_port.sv
// periph_in_port: 4-phase req/ack device input buffered in a FIFO and popped by IN instructions
module periph_in_port
   import proc_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ext_req,
   input  logic [DATA_WIDTH-1:0] ext_data,
   output logic                  ext_ack,
   input  logic                  exec_en,
   input  logic [1:0]            TypeCode,
   input  logic [3:0]            OpCode,
   output logic [DATA_WIDTH-1:0] peripheral_value,
   output logic                  periph_valid,
   output logic                  periph_full,
   output logic                  underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic                  req_s;
   pin_state_t            state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  pop, can_push, do_push, do_pop;
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .reset_n(reset_n), .d(ext_req), .q(req_s)
   );
   assign pop              = exec_en && TypeCode == TYPE_ALU && OpCode == OP_IN;
   assign periph_valid     = count != '0;
   assign periph_full      = count == CW'(DEPTH);
   assign can_push         = !periph_full || pop;
   assign do_push          = req_s && can_push && (state == PIN_IDLE || state == PIN_STALL);
   assign do_pop           = pop && periph_valid;
   assign peripheral_value = periph_valid ? mem[rd_ptr] : '0;
   always_ff @(posedge clk)
      if (!reset_n) begin
         state   <= PIN_IDLE;
         ext_ack <= 1'b0;
      end else
         case (state)
            PIN_IDLE, PIN_STALL: if (req_s) begin
               state   <= can_push ? PIN_ACK : PIN_STALL;
               ext_ack <= can_push;
            end
            PIN_ACK: if (!req_s) begin
               state   <= PIN_IDLE;
               ext_ack <= 1'b0;
            end
            default: begin
               state   <= PIN_IDLE;
               ext_ack <= 1'b0;
            end
         endcase
   // storage is deliberately unreset; visibility is governed by count alone
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= ext_data;
   always_ff @(posedge clk)
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         underflow <= 1'b0;
      end else begin
         wr_ptr    <= do_push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr    <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
         count     <= count + CW'(do_push) - CW'(do_pop);
         underflow <= underflow || (pop && !periph_valid);
      end
endmodule
